// File: rtl/axil2iob.sv
`timescale 1ns/1ps
// axil2iob: AXI4-Lite slave to native (valid/addr/wdata/wstrb/rdata/ready)
// master bridge. Sits behind the AXI-Lite interconnect in front of a native
// peripheral and performs one native access at a time.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   s_axil_aw*/w*/b*      AXI-Lite write address / data / response channels
//   s_axil_ar*/r*         AXI-Lite read address / data channels
//   valid, addr, wdata,   native request (wstrb == 0 marks a read)
//   wstrb
//   rdata, ready          native completion, single-cycle ready
//
// AW and W are accepted independently in any order; once a partial write is
// held, reads wait until that write has completed. Reads and writes are
// granted round-robin when both are pending in IDLE. A write with all strobes
// clear is answered with OKAY without touching the native bus.
module axil2iob #(
  parameter int unsigned AXIL_ADDR_W = 32,
  parameter int unsigned AXIL_DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AXIL_ADDR_W-1:0]   s_axil_awaddr,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  input  logic [AXIL_DATA_W-1:0]   s_axil_wdata,
  input  logic [AXIL_DATA_W/8-1:0] s_axil_wstrb,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  output logic [1:0]               s_axil_bresp,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,
  input  logic [AXIL_ADDR_W-1:0]   s_axil_araddr,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  output logic [AXIL_DATA_W-1:0]   s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  output logic                     valid,
  output logic [AXIL_ADDR_W-1:0]   addr,
  output logic [AXIL_DATA_W-1:0]   wdata,
  output logic [AXIL_DATA_W/8-1:0] wstrb,
  input  logic [AXIL_DATA_W-1:0]   rdata,
  input  logic                     ready
);

  localparam int unsigned STRB_W = AXIL_DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_B_RESP,
    ST_READ,
    ST_R_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic                   aw_held_q, aw_held_d;
  logic                   w_held_q, w_held_d;
  logic                   read_prio_q, read_prio_d;
  logic [AXIL_ADDR_W-1:0] addr_q, addr_d;
  logic [AXIL_DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]      wstrb_q, wstrb_d;
  logic [AXIL_DATA_W-1:0] rdata_q, rdata_d;

  logic awready_c, wready_c, arready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      read_prio_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      read_prio_q <= read_prio_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    read_prio_d = read_prio_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    awready_c   = 1'b0;
    wready_c    = 1'b0;
    arready_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A read is only granted with no partial write held; it wins when it
        // has priority or when no write channel is requesting.
        if (!aw_held_q && !w_held_q && s_axil_arvalid &&
            (read_prio_q || !(s_axil_awvalid || s_axil_wvalid))) begin
          arready_c = 1'b1;
          addr_d    = s_axil_araddr;
          state_d   = ST_READ;
        end else begin
          awready_c = !aw_held_q;
          wready_c  = !w_held_q;
          if (s_axil_awvalid && awready_c) begin
            addr_d    = s_axil_awaddr;
            aw_held_d = 1'b1;
          end
          if (s_axil_wvalid && wready_c) begin
            wdata_d  = s_axil_wdata;
            wstrb_d  = s_axil_wstrb;
            w_held_d = 1'b1;
          end
          // The next-state held flags include a beat accepted this cycle, so
          // the write launches in the same cycle its second half arrives.
          if (aw_held_d && w_held_d) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            state_d   = (wstrb_d != '0) ? ST_WRITE : ST_B_RESP;
          end
        end
      end
      ST_WRITE: begin
        if (ready) state_d = ST_B_RESP;
      end
      ST_READ: begin
        if (ready) begin
          rdata_d = rdata;
          state_d = ST_R_RESP;
        end
      end
      ST_B_RESP: begin
        if (s_axil_bready) begin
          state_d     = ST_IDLE;
          read_prio_d = 1'b1;
        end
      end
      ST_R_RESP: begin
        if (s_axil_rready) begin
          state_d     = ST_IDLE;
          read_prio_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_axil_awready = awready_c && !rst;
  assign s_axil_wready  = wready_c && !rst;
  assign s_axil_arready = arready_c && !rst;

  assign s_axil_bresp  = 2'b00;
  assign s_axil_bvalid = (state_q == ST_B_RESP);
  assign s_axil_rresp  = 2'b00;
  assign s_axil_rvalid = (state_q == ST_R_RESP);
  assign s_axil_rdata  = rdata_q;

  assign valid = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign wstrb = (state_q == ST_WRITE) ? wstrb_q : '0;

endmodule
